// File: rtl/tgate_switch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tgate_switch_sequencer_pkg
// Brief    : Shared state encoding and elaboration helpers for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tgate_switch_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEAD = 2'd1,
      ST_ON   = 2'd2
   } state_t;

   // Width of an index or counter that must hold values up to n-1 (never 0 bits).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit params_ok(input int dead_cyc, input int max_hold);
      return (dead_cyc >= 1) && (max_hold >= 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tgate_switch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tgate_switch_sequencer_if
// Brief    : Request/gate-control bundle between requesters and the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface tgate_switch_sequencer_if
   import tgate_switch_sequencer_pkg::*;
#(
   parameter int N = 4
) ();
   localparam int c_W = idx_width(N);

   logic [N-1:0]   req;
   logic [N-1:0]   en;
   logic [N-1:0]   en_n;
   logic [c_W-1:0] gnt_idx;
   logic           busy;

   modport master (output req, input en, input en_n, input gnt_idx, input busy);
   modport slave  (input req, output en, output en_n, output gnt_idx, output busy);
endinterface
`default_nettype wire

// File: rtl/tgate_switch_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tgate_switch_sequencer_rr_arbiter
// Brief    : Combinational round-robin pick starting after the last winner.
// Revision : 1.0 - initial release
// ============================================================================
module tgate_switch_sequencer_rr_arbiter
   import tgate_switch_sequencer_pkg::*;
#(
   parameter int N = 4,
   parameter int W = idx_width(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [N-1:0] i_mask,
   input  logic [W-1:0] i_last_winner,
   output logic [W-1:0] o_win_idx,
   output logic         o_win_valid
);
   logic [N-1:0] w_eligible;

   assign w_eligible = i_req & i_mask;

   // Walk the offsets from farthest to nearest so the nearest eligible one wins.
   always_comb begin
      o_win_idx   = '0;
      o_win_valid = 1'b0;
      for (int i = N; i >= 1; i--) begin
         if (w_eligible[(int'(i_last_winner) + i) % N]) begin
            o_win_idx   = W'((int'(i_last_winner) + i) % N);
            o_win_valid = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/tgate_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tgate_switch_sequencer
// Brief    : Break-before-make round-robin sequencer for a transmission-gate bank.
// Revision : 1.0 - initial release
// ============================================================================
module tgate_switch_sequencer
   import tgate_switch_sequencer_pkg::*;
#(
   parameter int N        = 4,
   parameter int DEAD_CYC = 2,
   parameter int MAX_HOLD = 16
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   tgate_switch_sequencer_if.slave bus
);
   localparam int           c_W   = idx_width(N);
   localparam int           c_DW  = idx_width(DEAD_CYC);
   localparam int           c_HW  = idx_width(MAX_HOLD + 1);
   localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

   if (!params_ok(DEAD_CYC, MAX_HOLD)) begin : g_param_bad
      $error("tgate_switch_sequencer: DEAD_CYC and MAX_HOLD must both be >= 1");
   end

   state_t          r_state;
   logic [N-1:0]    r_en;
   logic [N-1:0]    r_en_n;
   logic [c_W-1:0]  r_gnt;
   logic [c_W-1:0]  r_last;
   logic            r_busy;
   logic [c_DW-1:0] r_dead;
   logic [c_HW-1:0] r_hold;

   logic [N-1:0]    w_holder_oh;
   logic [N-1:0]    w_mask;
   logic [c_W-1:0]  w_win_idx;
   logic            w_win_valid;
   logic            w_hold_max;

   assign w_holder_oh = c_ONE << r_gnt;
   // While ON the holder never competes: it has either released or is being preempted.
   assign w_mask      = (r_state == ST_ON) ? ~w_holder_oh : {N{1'b1}};
   assign w_hold_max  = (r_hold == c_HW'(MAX_HOLD));

   tgate_switch_sequencer_rr_arbiter #(
      .N (N),
      .W (c_W)
   ) u_rr_arbiter (
      .i_req         (bus.req),
      .i_mask        (w_mask),
      .i_last_winner (r_last),
      .o_win_idx     (w_win_idx),
      .o_win_valid   (w_win_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_en    <= '0;
         r_en_n  <= '1;
         r_gnt   <= '0;
         r_last  <= c_W'(N - 1);
         r_busy  <= 1'b0;
         r_dead  <= '0;
         r_hold  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_win_valid) begin
                  r_gnt   <= w_win_idx;
                  r_dead  <= c_DW'(DEAD_CYC - 1);
                  r_busy  <= 1'b1;
                  r_state <= ST_DEAD;
               end
            end
            ST_DEAD: begin
               if (r_dead != '0) begin
                  r_dead <= r_dead - c_DW'(1);
               end else if (bus.req[r_gnt]) begin
                  r_en    <= w_holder_oh;
                  r_en_n  <= ~w_holder_oh;
                  r_hold  <= '0;
                  r_last  <= r_gnt;
                  r_state <= ST_ON;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_ON: begin
               if (!w_hold_max) begin
                  r_hold <= r_hold + c_HW'(1);
               end
               if (!bus.req[r_gnt] || (w_hold_max && w_win_valid)) begin
                  r_en   <= '0;
                  r_en_n <= '1;
                  if (w_win_valid) begin
                     r_gnt   <= w_win_idx;
                     r_dead  <= c_DW'(DEAD_CYC - 1);
                     r_state <= ST_DEAD;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_en    <= '0;
               r_en_n  <= '1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.en      = r_en;
   assign bus.en_n    = r_en_n;
   assign bus.gnt_idx = r_gnt;
   assign bus.busy    = r_busy;
endmodule
`default_nettype wire
